// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates ROB tags at dispatch, captures
// CDB results, answers operand-readiness queries and retires in program order.
module reorder_buffer #(
    parameter int unsigned ROB_DEPTH = 8,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_W     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             dispatch_valid,
    input  logic [REG_W-1:0] dispatch_dest_reg,
    input  logic [XLEN-1:0]  dispatch_pc,
    output logic [TAG_W-1:0] alloc_slot,
    output logic             rob_full,
    output logic             rob_empty,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_rob_tag,
    input  logic [XLEN-1:0]  cdb_value,
    input  logic [TAG_W-1:0] query_tag1,
    output logic             query_ready1,
    output logic [XLEN-1:0]  query_value1,
    input  logic [TAG_W-1:0] query_tag2,
    output logic             query_ready2,
    output logic [XLEN-1:0]  query_value2,
    output logic             commit_valid,
    output logic [TAG_W-1:0] commit_tag,
    output logic [REG_W-1:0] commit_dest_reg,
    output logic [XLEN-1:0]  commit_value,
    output logic [XLEN-1:0]  commit_pc
);

    localparam int unsigned PTR_W = $clog2(ROB_DEPTH);
    localparam int unsigned CNT_W = $clog2(ROB_DEPTH + 1);

    typedef struct packed {
        logic [REG_W-1:0] dest_reg;
        logic [XLEN-1:0]  pc;
    } meta_t;

    logic [ROB_DEPTH-1:0] valid_q;
    logic [ROB_DEPTH-1:0] done_q;
    meta_t                meta_q  [ROB_DEPTH];
    logic [XLEN-1:0]      value_q [ROB_DEPTH];
    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [CNT_W-1:0]     count_q;

    logic                 dispatch_fire;
    logic                 commit_fire;
    logic                 cdb_capture;
    logic [PTR_W-1:0]     cdb_idx;

    // Tag 0 means "value in regfile"; tags above ROB_DEPTH name no entry.
    function automatic logic tag_in_range(input logic [TAG_W-1:0] tag);
        return (tag != '0) && (32'(tag) <= ROB_DEPTH);
    endfunction

    function automatic logic [PTR_W-1:0] tag_idx(input logic [TAG_W-1:0] tag);
        return PTR_W'(tag - TAG_W'(1));
    endfunction

    assign rob_full   = (count_q == CNT_W'(ROB_DEPTH));
    assign rob_empty  = (count_q == '0);
    assign alloc_slot = TAG_W'(tail_q) + TAG_W'(1);

    // Dispatch/commit/capture qualification from pre-edge state.
    always_comb begin
        dispatch_fire = dispatch_valid & ~rob_full;
        commit_fire   = valid_q[head_q] & done_q[head_q];
        cdb_idx       = tag_idx(cdb_rob_tag);
        cdb_capture   = cdb_valid && tag_in_range(cdb_rob_tag) && valid_q[cdb_idx]
                        && !(dispatch_fire && (cdb_rob_tag == alloc_slot));
    end

    logic [TAG_W-1:0] q_tag   [2];
    logic             q_ready [2];
    logic [XLEN-1:0]  q_value [2];

    assign q_tag[0]     = query_tag1;
    assign q_tag[1]     = query_tag2;
    assign query_ready1 = q_ready[0];
    assign query_value1 = q_value[0];
    assign query_ready2 = q_ready[1];
    assign query_value2 = q_value[1];

    for (genvar g = 0; g < 2; g++) begin : g_query
        logic [PTR_W-1:0] idx;
        assign idx = tag_idx(q_tag[g]);

        // Operand lookup with same-cycle CDB bypass taking priority.
        always_comb begin
            q_ready[g] = 1'b0;
            q_value[g] = '0;
            if (tag_in_range(q_tag[g]) && valid_q[idx]) begin
                if (cdb_valid && (cdb_rob_tag == q_tag[g])) begin
                    q_ready[g] = 1'b1;
                    q_value[g] = cdb_value;
                end else if (done_q[idx]) begin
                    q_ready[g] = 1'b1;
                    q_value[g] = value_q[idx];
                end
            end
        end
    end

    // Entry state, pointers, occupancy and registered commit port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q         <= '0;
            done_q          <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            commit_valid    <= 1'b0;
            commit_tag      <= '0;
            commit_dest_reg <= '0;
            commit_value    <= '0;
            commit_pc       <= '0;
            for (int i = 0; i < int'(ROB_DEPTH); i++) begin
                meta_q[PTR_W'(i)]  <= '0;
                value_q[PTR_W'(i)] <= '0;
            end
        end else if (flush) begin
            valid_q      <= '0;
            done_q       <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            commit_valid <= 1'b0;
        end else begin
            if (dispatch_fire) begin
                valid_q[tail_q]         <= 1'b1;
                done_q[tail_q]          <= 1'b0;
                meta_q[tail_q].dest_reg <= dispatch_dest_reg;
                meta_q[tail_q].pc       <= dispatch_pc;
                tail_q                  <= tail_q + PTR_W'(1);
            end
            if (cdb_capture) begin
                done_q[cdb_idx]  <= 1'b1;
                value_q[cdb_idx] <= cdb_value;
            end
            commit_valid <= commit_fire;
            if (commit_fire) begin
                commit_tag      <= TAG_W'(head_q) + TAG_W'(1);
                commit_dest_reg <= meta_q[head_q].dest_reg;
                commit_value    <= value_q[head_q];
                commit_pc       <= meta_q[head_q].pc;
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(dispatch_fire) - CNT_W'(commit_fire);
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios with literal expectations plus
// randomized traffic checked against a queue-based program-order model.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        dispatch_valid;
    logic [4:0]  dispatch_dest_reg;
    logic [31:0] dispatch_pc;
    logic [3:0]  alloc_slot;
    logic        rob_full;
    logic        rob_empty;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_tag;
    logic [31:0] cdb_value;
    logic [3:0]  query_tag1;
    logic        query_ready1;
    logic [31:0] query_value1;
    logic [3:0]  query_tag2;
    logic        query_ready2;
    logic [31:0] query_value2;
    logic        commit_valid;
    logic [3:0]  commit_tag;
    logic [4:0]  commit_dest_reg;
    logic [31:0] commit_value;
    logic [31:0] commit_pc;

    reorder_buffer #(.ROB_DEPTH(8), .TAG_W(4), .XLEN(32), .REG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_dest_reg(dispatch_dest_reg),
        .dispatch_pc(dispatch_pc), .alloc_slot(alloc_slot),
        .rob_full(rob_full), .rob_empty(rob_empty),
        .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag), .cdb_value(cdb_value),
        .query_tag1(query_tag1), .query_ready1(query_ready1), .query_value1(query_value1),
        .query_tag2(query_tag2), .query_ready2(query_ready2), .query_value2(query_value2),
        .commit_valid(commit_valid), .commit_tag(commit_tag),
        .commit_dest_reg(commit_dest_reg), .commit_value(commit_value), .commit_pc(commit_pc)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Program-order model: queue of in-flight instructions, oldest first.
    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  dest;
        logic [31:0] pc;
        bit          done;
        logic [31:0] value;
    } ent_t;

    ent_t        mq[$];
    int          next_tag = 1;
    bit          e_cv;
    logic [3:0]  e_ctag;
    logic [4:0]  e_cdest;
    logic [31:0] e_cval;
    logic [31:0] e_cpc;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        next_tag = 1;
        e_cv     = 1'b0;
        e_ctag   = '0;
        e_cdest  = '0;
        e_cval   = '0;
        e_cpc    = '0;
    endfunction

    function automatic void model_edge();
        bit   com;
        bit   disp;
        ent_t e;
        if (flush) begin
            mq.delete();
            next_tag = 1;
            e_cv     = 1'b0;
            return;
        end
        com  = (mq.size() > 0) && mq[0].done;
        disp = dispatch_valid && (mq.size() < 8);
        e_cv = com;
        if (com) begin
            e_ctag  = mq[0].tag;
            e_cdest = mq[0].dest;
            e_cval  = mq[0].value;
            e_cpc   = mq[0].pc;
        end
        if (cdb_valid) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].tag == cdb_rob_tag) begin
                    mq[i].done  = 1'b1;
                    mq[i].value = cdb_value;
                end
            end
        end
        if (com) void'(mq.pop_front());
        if (disp) begin
            e.tag   = 4'(next_tag);
            e.dest  = dispatch_dest_reg;
            e.pc    = dispatch_pc;
            e.done  = 1'b0;
            e.value = '0;
            mq.push_back(e);
            next_tag = (next_tag == 8) ? 1 : next_tag + 1;
        end
    endfunction

    function automatic void model_query(input logic [3:0] tag, output bit r, output logic [31:0] v);
        r = 1'b0;
        v = '0;
        if (tag != 0) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].tag == tag) begin
                    if (cdb_valid && cdb_rob_tag == tag) begin
                        r = 1'b1;
                        v = cdb_value;
                    end else if (mq[i].done) begin
                        r = 1'b1;
                        v = mq[i].value;
                    end
                end
            end
        end
    endfunction

    function automatic void check_comb();
        bit          r;
        logic [31:0] v;
        chk("rob_full", rob_full, mq.size() == 8);
        chk("rob_empty", rob_empty, mq.size() == 0);
        chk("alloc_slot", alloc_slot, next_tag);
        model_query(query_tag1, r, v);
        chk("query_ready1", query_ready1, r);
        if (r || query_tag1 == 0) chk("query_value1", query_value1, v);
        model_query(query_tag2, r, v);
        chk("query_ready2", query_ready2, r);
        if (r || query_tag2 == 0) chk("query_value2", query_value2, v);
    endfunction

    function automatic void check_regs();
        chk("commit_valid", commit_valid, e_cv);
        chk("commit_tag", commit_tag, e_ctag);
        chk("commit_dest_reg", commit_dest_reg, e_cdest);
        chk("commit_value", commit_value, e_cval);
        chk("commit_pc", commit_pc, e_cpc);
    endfunction

    // Compare process: combinational outputs mid-cycle, commit port after each edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (chk_en && reset) check_comb();
            @(posedge clk);
            if (!reset) model_reset();
            else if (chk_en) model_edge();
            #1;
            if (chk_en && reset) check_regs();
        end
    end

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic idle();
        dispatch_valid = 1'b0;
        cdb_valid      = 1'b0;
        flush          = 1'b0;
        query_tag1     = '0;
        query_tag2     = '0;
    endtask

    task automatic disp(input logic [4:0] dest, input logic [31:0] pc);
        dispatch_valid    = 1'b1;
        dispatch_dest_reg = dest;
        dispatch_pc       = pc;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
        cdb_valid   = 1'b1;
        cdb_rob_tag = tag;
        cdb_value   = val;
    endtask

    // Asynchronous reset pulse fully between two clock edges.
    task automatic pulse_reset();
        #4 reset = 1'b0;
        #1;
        chk("async_rst_empty", rob_empty, 1);
        chk("async_rst_full", rob_full, 0);
        chk("async_rst_alloc", alloc_slot, 1);
        chk("async_rst_cv", commit_valid, 0);
        chk("async_rst_ctag", commit_tag, 0);
        chk("async_rst_cval", commit_value, 0);
        model_reset();
        #1 reset = 1'b1;
    endtask

    function automatic logic [3:0] pick_tag();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6 && mq.size() > 0) return mq[$urandom_range(0, mq.size() - 1)].tag;
        if (r < 8) return 4'(next_tag);
        return 4'($urandom);
    endfunction

    initial begin
        reset = 1'b0;
        idle();
        dispatch_dest_reg = '0;
        dispatch_pc       = '0;
        cdb_rob_tag       = '0;
        cdb_value         = '0;
        repeat (2) adv();
        chk("rst_empty", rob_empty, 1);
        chk("rst_full", rob_full, 0);
        chk("rst_alloc", alloc_slot, 1);
        chk("rst_cv", commit_valid, 0);
        chk("rst_ctag", commit_tag, 0);
        chk("rst_cval", commit_value, 0);
        reset = 1'b1;
        model_reset();
        chk_en = 1'b1;

        // Three dispatches receive tags 1,2,3.
        for (int k = 1; k <= 3; k++) begin
            disp(5'(k), 32'h100 + 32'(4 * (k - 1)));
            #1 chk("alloc_seq", alloc_slot, k);
            adv();
        end
        idle();
        chk("three_nonempty", rob_empty, 0);
        chk("three_nocommit", commit_valid, 0);

        // Out-of-order completion, in-order retirement.
        cdb(4'd2, 32'h22);
        adv(); idle(); adv();
        chk("no_commit_tag2_first", commit_valid, 0);
        cdb(4'd1, 32'h11);
        adv(); idle(); adv();
        chk("commit1_valid", commit_valid, 1);
        chk("commit1_tag", commit_tag, 1);
        chk("commit1_value", commit_value, 32'h11);
        chk("commit1_dest", commit_dest_reg, 1);
        chk("commit1_pc", commit_pc, 32'h100);
        adv();
        chk("commit2_valid", commit_valid, 1);
        chk("commit2_tag", commit_tag, 2);
        chk("commit2_value", commit_value, 32'h22);
        chk("commit2_pc", commit_pc, 32'h104);
        adv();
        chk("commit3_wait", commit_valid, 0);

        // Fill to capacity, reject the ninth, wrap after one retirement.
        flush = 1'b1;
        adv(); idle();
        chk("flush_alloc", alloc_slot, 1);
        chk("flush_empty", rob_empty, 1);
        for (int k = 1; k <= 8; k++) begin
            disp(5'(k + 8), 32'h200 + 32'(4 * k));
            #1 chk("alloc_fill", alloc_slot, k);
            adv();
        end
        chk("full_after8", rob_full, 1);
        disp(5'd31, 32'h999);
        adv();
        chk("ninth_ignored_full", rob_full, 1);
        chk("ninth_alloc", alloc_slot, 1);
        cdb(4'd1, 32'h1111);
        adv();
        cdb_valid = 1'b0;
        adv();
        chk("wrap_commit_valid", commit_valid, 1);
        chk("wrap_commit_tag", commit_tag, 1);
        chk("wrap_commit_value", commit_value, 32'h1111);
        chk("wrap_commit_pc", commit_pc, 32'h204);
        chk("full_commit_no_admit", rob_full, 0);
        chk("wrap_alloc", alloc_slot, 1);
        dispatch_valid = 1'b0;

        // Same-cycle CDB bypass on query.
        query_tag1 = 4'd3;
        query_tag2 = 4'd0;
        cdb(4'd3, 32'hABCD);
        #1;
        chk("bypass_ready1", query_ready1, 1);
        chk("bypass_value1", query_value1, 32'hABCD);
        chk("tag0_ready2", query_ready2, 0);
        chk("tag0_value2", query_value2, 0);
        query_tag2 = 4'd4;
        #1 chk("pending_ready2", query_ready2, 0);
        adv();
        cdb_valid = 1'b0;
        #1;
        chk("stored_ready1", query_ready1, 1);
        chk("stored_value1", query_value1, 32'hABCD);
        idle();
        adv();

        // Flush with five in flight plus concurrent dispatch and CDB.
        flush = 1'b1;
        adv(); idle();
        for (int k = 1; k <= 5; k++) begin
            disp(5'(k), 32'h300 + 32'(k));
            adv();
        end
        disp(5'd7, 32'h377);
        cdb(4'd2, 32'h5);
        flush = 1'b1;
        adv(); idle();
        chk("flush5_empty", rob_empty, 1);
        chk("flush5_full", rob_full, 0);
        chk("flush5_cv", commit_valid, 0);
        chk("flush5_alloc", alloc_slot, 1);
        adv();
        chk("flush5_cv_next", commit_valid, 0);

        // Asynchronous reset with four in flight, tags 2 and 3 done.
        for (int k = 1; k <= 4; k++) begin
            disp(5'(k + 20), 32'h400 + 32'(k));
            adv();
        end
        idle();
        cdb(4'd2, 32'h202);
        adv();
        cdb(4'd3, 32'h303);
        adv(); idle();
        chk("pre_rst_nonempty", rob_empty, 0);
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            adv();
            chk("post_rst_nocommit", commit_valid, 0);
        end

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            dispatch_valid    = ($urandom_range(0, 99) < 55);
            dispatch_dest_reg = 5'($urandom);
            dispatch_pc       = $urandom;
            cdb_valid         = ($urandom_range(0, 1) == 1);
            cdb_rob_tag       = pick_tag();
            cdb_value         = $urandom;
            query_tag1        = pick_tag();
            query_tag2        = pick_tag();
            flush             = ($urandom_range(0, 99) == 0);
            if (c == 1500) pulse_reset();
            adv();
        end
        idle();
        adv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer that sits directly upstream of the reservation station.
- Allocates the ROB tag (alloc_slot) for each dispatched instruction and captures results broadcast on the CDB.
- Answers operand-tag queries so dispatch can mark sources ready, and retires completed instructions in program order to the register file.
- Tag 0 is reserved to mean "no producer / value in regfile"; valid tags are 1..ROB_DEPTH.

Parameters:
ROB_DEPTH, 8, number of entries (power of two, >=2)
TAG_W, 4, tag width = clog2(ROB_DEPTH+1)
XLEN, 32, data width
REG_W, 5, architectural register index width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous squash of all entries
dispatch_valid  in  1  instruction offered for allocation
dispatch_dest_reg  in  REG_W  architectural destination (0 = no writeback)
dispatch_pc  in  XLEN  PC of dispatched instruction
alloc_slot  out  TAG_W  tag the offered instruction receives (combinational)
rob_full  out  1  no free entry
rob_empty  out  1  no valid entry
cdb_valid  in  1  CDB broadcast valid
cdb_rob_tag  in  TAG_W  completing tag
cdb_value  in  XLEN  result value
query_tag1  in  TAG_W  rs1 producer tag from map table
query_ready1  out  1  rs1 result available
query_value1  out  XLEN  rs1 result
query_tag2  in  TAG_W  rs2 producer tag
query_ready2  out  1  rs2 result available
query_value2  out  XLEN  rs2 result
commit_valid  out  1  one instruction retired this cycle (registered)
commit_tag  out  TAG_W  retired tag
commit_dest_reg  out  REG_W  retired destination
commit_value  out  XLEN  retired value
commit_pc  out  XLEN  retired PC

Behaviour:
- Reset: clk and reset only; reset is asynchronous and active-low.
  - Asserting reset clears all valid/done bits, head=tail=0, count=0.
  - commit_* = 0, rob_empty=1, rob_full=0, alloc_slot=1.
  - Reset mid-operation discards all in-flight entries.
- State per entry: valid, done, dest_reg, pc, value.
  - Index i holds tag i+1.
  - head, tail are log2(ROB_DEPTH)-bit pointers and wrap naturally.
  - count is 0..ROB_DEPTH.
- alloc_slot = tail+1, combinational, valid whenever rob_full=0.
- rob_full = (count==ROB_DEPTH); rob_empty = (count==0); both combinational from registered count.
- Dispatch:
  - Accepted when dispatch_valid & ~rob_full, with rob_full evaluated before the edge.
  - At the edge the entry is written: valid=1, done=0. Tail increments and wraps ROB_DEPTH-1 -> 0.
  - A rejected dispatch changes no state; the upstream stage holds.
- CDB capture:
  - On cdb_valid, the entry with tag cdb_rob_tag gets value=cdb_value, done=1 at the edge, if that entry is valid.
  - A broadcast to an invalid entry or to tag 0 is ignored.
  - A broadcast to the tag being allocated the same cycle is ignored.
- Query (combinational):
  - query_readyN=1 if tagN!=0, entry valid, and (entry done, or cdb_valid with cdb_rob_tag==tagN). The same-cycle CDB bypass takes priority for the value.
  - tagN==0 gives readyN=0, valueN=0. The regfile path is used instead.
- Commit:
  - If the head entry is valid & done, at the edge: commit_valid<=1 and commit_* <= head fields; the entry is invalidated and head increments.
  - Otherwise commit_valid<=0.
  - At most one commit per cycle.
  - CDB completing the head in cycle N gives commit_valid in cycle N+2. Done is set at edge N+1 and commit is registered at edge N+2.
- Simultaneous events: dispatch and commit in the same cycle leave count unchanged. Full + commit does not admit the dispatch that cycle.
- flush (priority over dispatch/CDB/commit):
  - At the edge, clear all valid/done bits, head=tail=0, count=0, commit_valid<=0.
  - The next alloc_slot is 1.

Test Plan:
- Reset low then high, dispatch 3 instrs (dest 1,2,3) -> alloc_slot 1,2,3; count 3; rob_empty=0; no commit.
- CDB tag 2 value 0x22, then tag 1 value 0x11 -> no commit after tag 2; then commits tag1/0x11 and tag2/0x22 on consecutive cycles, in order.
- Dispatch 8 with no completions -> rob_full=1 and the 9th dispatch is ignored. Complete and commit tag 1 -> next alloc_slot=1 (wrap); rob_full=0.
- query_tag1=3 with cdb_valid, cdb_rob_tag=3, cdb_value=0xABCD same cycle -> query_ready1=1, query_value1=0xABCD before capture; query_tag2=0 -> ready2=0.
- 5 valid entries, flush with concurrent dispatch and CDB -> count 0, rob_empty=1, commit_valid=0, next alloc_slot=1.
- reset pulsed low asynchronously between edges with 4 entries, 2 done -> outputs cleared immediately; no commit after release.
